// File: rtl/pdl_pkg.sv
// rtl/pdl_pkg.sv - shared light states, light encodings and output width helper
// Contents:
//   light_state_t  RED, RED_AMBER, GREEN, AMBER
//   LIGHT_*        3-bit {red,amber,green} lamp encodings
//   out_w()        result width: max(3, clog2(sides+1))
//   light_code()   state to lamp encoding
package pdl_pkg;

   typedef enum logic [1:0] {
      RED       = 2'd0,
      RED_AMBER = 2'd1,
      GREEN     = 2'd2,
      AMBER     = 2'd3
   } light_state_t;

   localparam logic [2:0] LIGHT_RED       = 3'b100;
   localparam logic [2:0] LIGHT_RED_AMBER = 3'b110;
   localparam logic [2:0] LIGHT_GREEN     = 3'b001;
   localparam logic [2:0] LIGHT_AMBER     = 3'b010;

   function automatic int out_w(input int sides);
      int w;
      w = $clog2(sides + 1);
      return (w < 3) ? 3 : w;
   endfunction

   function automatic logic [2:0] light_code(input light_state_t s);
      case (s)
         RED:       return LIGHT_RED;
         RED_AMBER: return LIGHT_RED_AMBER;
         GREEN:     return LIGHT_GREEN;
         AMBER:     return LIGHT_AMBER;
         default:   return LIGHT_RED;
      endcase
   endfunction

endpackage

// File: rtl/pdl_light_fsm.sv
// rtl/pdl_light_fsm.sv - traffic-light sequencer with optional dwell timing
// Build option: PARAM_DICE_LIGHTS_DWELL_EN enables the dwell counter and the
// pedestrian shortcut; without it the sequencer steps one state per cycle.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   ped     in   pedestrian request (only present with the dwell build)
//   lights  out  {red,amber,green} of the current state
module pdl_light_fsm
   import pdl_pkg::*;
#(
   parameter int RED_CYC   = 4,
   parameter int RA_CYC    = 1,
   parameter int GREEN_CYC = 4,
   parameter int AMBER_CYC = 1,
   parameter int GREEN_MIN = 1
) (
   input  logic       clk,
   input  logic       rst,
`ifdef PARAM_DICE_LIGHTS_DWELL_EN
   input  logic       ped,
`endif
   output logic [2:0] lights
);

   if (RED_CYC < 1 || RA_CYC < 1 || GREEN_CYC < 1 || AMBER_CYC < 1 ||
       GREEN_MIN < 1 || GREEN_MIN > GREEN_CYC) begin : g_bad_params
      $error("pdl_light_fsm: illegal dwell parameters");
   end

   light_state_t state;
   light_state_t state_nxt;

`ifdef PARAM_DICE_LIGHTS_DWELL_EN
   localparam int CYC_MAX_A = (RED_CYC > RA_CYC) ? RED_CYC : RA_CYC;
   localparam int CYC_MAX_B = (GREEN_CYC > AMBER_CYC) ? GREEN_CYC : AMBER_CYC;
   localparam int CYC_MAX   = (CYC_MAX_A > CYC_MAX_B) ? CYC_MAX_A : CYC_MAX_B;
   localparam int DW        = $clog2(CYC_MAX + 1);
   // dwell counts down the cycles left in the state; a pedestrian may leave
   // GREEN once GREEN_MIN cycles have elapsed, i.e. dwell <= GREEN_LEAVE
   localparam int GREEN_LEAVE = GREEN_CYC - GREEN_MIN + 1;

   logic [DW-1:0] dwell;
   logic [DW-1:0] dwell_nxt;

   function automatic logic [DW-1:0] cyc_of(input light_state_t s);
      case (s)
         RED:       return DW'(RED_CYC);
         RED_AMBER: return DW'(RA_CYC);
         GREEN:     return DW'(GREEN_CYC);
         AMBER:     return DW'(AMBER_CYC);
         default:   return DW'(RED_CYC);
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RED;
         dwell <= DW'(RED_CYC);
      end else begin
         state <= state_nxt;
         dwell <= dwell_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      dwell_nxt = dwell - DW'(1);
      case (state)
         RED:       if (dwell <= DW'(1)) state_nxt = RED_AMBER;
         RED_AMBER: if (dwell <= DW'(1)) state_nxt = GREEN;
         GREEN:     if (dwell <= DW'(1) || (ped && dwell <= DW'(GREEN_LEAVE)))
                       state_nxt = AMBER;
         AMBER:     if (dwell <= DW'(1)) state_nxt = RED;
         default:   state_nxt = RED;
      endcase
      // reload on every transition, including recovery from a bad encoding
      if (state_nxt != state || state_nxt == RED && state != AMBER && state != RED)
         dwell_nxt = cyc_of(state_nxt);
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RED;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = RED;
      case (state)
         RED:       state_nxt = RED_AMBER;
         RED_AMBER: state_nxt = GREEN;
         GREEN:     state_nxt = AMBER;
         AMBER:     state_nxt = RED;
         default:   state_nxt = RED;
      endcase
   end
`endif

   assign lights = light_code(state);

endmodule

// File: rtl/param_dice_lights.sv
// rtl/param_dice_lights.sv - dice counter / traffic lights with a shared registered output
// Build option: PARAM_DICE_LIGHTS_DWELL_EN (see pdl_light_fsm).
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   button      in   dice roll enable; pedestrian request in lights mode
//   sel         in   0 = dice, 1 = traffic lights
//   result      out  registered dice face or zero-extended {red,amber,green}
//   throw_done  out  one-cycle pulse after button falls in dice mode
module param_dice_lights
   import pdl_pkg::*;
#(
   parameter int SIDES     = 6,
   parameter int RED_CYC   = 4,
   parameter int RA_CYC    = 1,
   parameter int GREEN_CYC = 4,
   parameter int AMBER_CYC = 1,
   parameter int GREEN_MIN = 1,
   localparam int OUT_W    = out_w(SIDES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             button,
   input  logic             sel,
   output logic [OUT_W-1:0] result,
   output logic             throw_done
);

   if (SIDES < 2 || SIDES > 15) begin : g_bad_sides
      $error("param_dice_lights: SIDES out of range");
   end

   localparam logic [OUT_W-1:0] SIDES_V = OUT_W'(SIDES);
   localparam logic [OUT_W-1:0] ONE     = OUT_W'(1);

   logic [OUT_W-1:0] dice;
   logic             button_q;
   logic [2:0]       lights;

`ifdef PARAM_DICE_LIGHTS_DWELL_EN
   logic ped;
   assign ped = button & sel;
`endif

   pdl_light_fsm #(
      .RED_CYC   (RED_CYC),
      .RA_CYC    (RA_CYC),
      .GREEN_CYC (GREEN_CYC),
      .AMBER_CYC (AMBER_CYC),
      .GREEN_MIN (GREEN_MIN)
   ) u_fsm (
      .clk    (clk),
      .rst    (rst),
`ifdef PARAM_DICE_LIGHTS_DWELL_EN
      .ped    (ped),
`endif
      .lights (lights)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dice       <= ONE;
         button_q   <= 1'b0;
         result     <= '0;
         throw_done <= 1'b0;
      end else begin
         // out-of-range faces self-heal regardless of button
         if (dice == '0 || dice > SIDES_V)
            dice <= ONE;
         else if (button)
            dice <= (dice == SIDES_V) ? ONE : dice + ONE;
         button_q <= button;
         // a fall coinciding with entry to lights mode is not a throw
         throw_done <= button_q & ~button & ~sel;
         result     <= sel ? OUT_W'(lights) : dice;
      end
   end

endmodule

// File: tb/tb_param_dice_lights.sv
// tb/tb_param_dice_lights.sv - scoreboard bench for param_dice_lights (two parameter sets)
module tb_param_dice_lights;

   logic       clk = 1'b0;
   logic       rst;
   logic       button;
   logic       sel;
   logic [2:0] result_a;
   logic       td_a;
   logic [3:0] result_b;
   logic       td_b;

   always #5 clk = ~clk;

   param_dice_lights u_a (
      .clk(clk), .rst(rst), .button(button), .sel(sel),
      .result(result_a), .throw_done(td_a)
   );

   param_dice_lights #(
      .SIDES(12), .RED_CYC(3), .RA_CYC(2), .GREEN_CYC(5), .AMBER_CYC(1), .GREEN_MIN(2)
   ) u_b (
      .clk(clk), .rst(rst), .button(button), .sel(sel),
      .result(result_b), .throw_done(td_b)
   );

   typedef struct {
      int res;
      bit td;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int vectors     = 0;
   int miscompares = 0;

   int m_sides[2]  = '{6, 12};
   int m_cyc[2][4] = '{'{4, 1, 4, 1}, '{3, 2, 5, 1}};
   int m_gmin[2]   = '{1, 2};
   int lamp[4]     = '{4, 6, 1, 2};   // RED, RED_AMBER, GREEN, AMBER as {r,a,g}

   int dice[2];
   int phase[2];
   int elapsed[2];
   bit prev[2];

   function automatic void check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         dice[k]    = 1;
         phase[k]   = 0;
         elapsed[k] = 1;
         prev[k]    = 1'b0;
      end
   endfunction

   // expected output after the coming rising edge, then advance the model
   function automatic void model_edge();
      for (int k = 0; k < 2; k++) begin
         exp_t e;
         if (rst) begin
            e.res = 0;
            e.td  = 1'b0;
            dice[k] = 1; phase[k] = 0; elapsed[k] = 1; prev[k] = 1'b0;
         end else begin
            e.res = sel ? lamp[phase[k]] : dice[k];
            e.td  = prev[k] && !button && !sel;
            if (button) dice[k] = dice[k] % m_sides[k] + 1;
`ifdef PARAM_DICE_LIGHTS_DWELL_EN
            if (elapsed[k] >= m_cyc[k][phase[k]] ||
                (phase[k] == 2 && button && sel && elapsed[k] >= m_gmin[k])) begin
               phase[k]   = (phase[k] + 1) % 4;
               elapsed[k] = 1;
            end else begin
               elapsed[k]++;
            end
`else
            phase[k] = (phase[k] + 1) % 4;
`endif
            prev[k] = button;
         end
         if (k == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
   endfunction

   task automatic cyc(input bit r, input bit b, input bit s);
      @(negedge clk);
      rst    = r;
      button = b;
      sel    = s;
      model_edge();
   endtask

   // monitor: result is registered every cycle, so each edge presents a value
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin
            exp_t e;
            e = q0.pop_front();
            check("res_a", int'(result_a), e.res);
            check("td_a", int'(td_a), int'(e.td));
         end
         if (q1.size() > 0) begin
            exp_t e;
            e = q1.pop_front();
            check("res_b", int'(result_b), e.res);
            check("td_b", int'(td_b), int'(e.td));
         end
      end
   end

   initial begin
      rst = 1'b1; button = 1'b0; sel = 1'b0;
      model_reset();
      repeat (3) cyc(1, 0, 0);

      // wrap through the face count, then release for a throw
      repeat (14) cyc(0, 1, 0);
      repeat (3) cyc(0, 0, 0);

      // roll to 4, enter lights mode on the same edge the button falls
      for (int i = 0; i < 16 && dice[0] != 4; i++) cyc(0, 1, 0);
      repeat (7) cyc(0, 0, 1);
      repeat (3) cyc(0, 0, 0);

      // lights with and without pedestrian, button toggling in lights mode
      repeat (24) cyc(0, 0, 1);
      repeat (20) cyc(0, 1, 1);
      repeat (10) cyc(0, ($urandom_range(0, 1) == 1), 1);

      // fresh reset, then async reset between edges while in GREEN
      repeat (2) cyc(1, 0, 1);
      for (int i = 0; i < 20 && phase[0] != 2; i++) cyc(0, 0, 1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_res_a", int'(result_a), 0);
      check("async_res_b", int'(result_b), 0);
      check("async_td_a", int'(td_a), 0);
      model_reset();
      repeat (2) cyc(1, 1, 1);
      repeat (12) cyc(0, 0, 1);

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         bit r, b, s;
         r = ($urandom_range(0, 63) == 0);
         b = ($urandom_range(0, 2) != 0);
         s = ($urandom_range(0, 7) == 0) ? ~sel : sel;
         cyc(r, b, s);
      end

      repeat (3) @(posedge clk);
      #2;
      if (q0.size() != 0 || q1.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d/%0d expected values never checked", q0.size(), q1.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
